ppu_ram_responder: RTL and testbench
====================================

Name: ppu_ram_responder

Overview:
- Synthesizable external-memory responder that sits directly upstream of the console's PPU memory port.
- Consumes the PPU's 4-bit serial address stream (addr_pins) and returns 16-bit words as 4-bit nibbles on data_pins.
- Backed by a synchronous single-port RAM.
- Used on FPGA test rigs and in system simulation; also provides a host load port for filling RAM with tiles, sprites and palettes before releasing the PPU from reset.

Parameters:
- RAM_PINS, 4, serial nibble width; fixed at 4, other values unsupported.
- ADDR_BITS, 16, word address width; always 4 nibbles.
- RESP_DELAY, 2, cycles from last address nibble to first data nibble, minus 1; legal range 2..7.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- addr_pins  in  4  serial command/address nibbles from the PPU.
- data_pins  out  4  serial data nibbles to the PPU; 0 when idle.
- mem_addr  out  16  RAM word address.
- mem_rd_en  out  1  RAM read strobe; data is valid on mem_rdata one cycle later.
- mem_rdata  in  16  RAM read data.
- mem_wr_en  out  1  RAM write strobe.
- mem_wdata  out  16  RAM write data.
- load_start  in  1  pulse: set the load pointer to load_addr.
- load_addr  in  16  start address for loading.
- load_valid  in  1  host word available.
- load_data  in  16  host word.
- load_ready  out  1  the word is accepted when load_valid && load_ready.
- busy  out  1  a read transaction is in progress (FSM not IDLE).
- proto_err  out  1  one-cycle pulse on an illegal or ignored command nibble.

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM goes to IDLE and all outputs go to 0, except load_ready=1. The load pointer goes to 0. Reset mid-transaction aborts the transaction, and data_pins is 0 on the next cycle.
- Command nibbles: 4'h0 = idle; 4'h1 = READ; every other value is illegal.
- FSM states: IDLE, ADDR, WAIT, DATA.
- IDLE:
  - addr_pins==1 -> ADDR, nibble counter cleared.
  - addr_pins==0 -> stay in IDLE.
  - any other value -> pulse proto_err, stay in IDLE.
- ADDR: shift in 4 nibbles, MSB first (A[15:12] first). After the 4th nibble (cycle t4, where t0 is the command cycle) go to WAIT.
- WAIT:
  - mem_rd_en=1 and mem_addr=assembled address at t5, one cycle only.
  - mem_rdata is captured into the output shift register at t6.
  - Wait counter runs RESP_DELAY-1 cycles, then -> DATA.
- DATA:
  - data_pins driven from a register with D[15:12], D[11:8], D[7:4], D[3:0] on cycles t4+RESP_DELAY+1 .. t4+RESP_DELAY+4.
  - Then -> IDLE; data_pins returns to 0 on the following cycle.
- Back-to-back reads: a new READ command nibble is accepted in the cycle immediately after the last data nibble.
- Command/address nibbles arriving while the FSM is in WAIT or DATA:
  - a non-zero nibble pulses proto_err and is ignored;
  - the transaction in progress completes unchanged.
- Load port:
  - load_start overrides any load handshake in the same cycle; that handshake is not accepted.
  - On an accepted word: mem_wr_en=1, mem_addr=pointer, mem_wdata=load_data in the same cycle (combinational from the handshake); pointer increments by 1 modulo 2^16, so 16'hFFFF wraps to 0.
- Port arbitration:
  - load_ready=0 in exactly the cycle where mem_rd_en=1, so a read always wins.
  - mem_addr is muxed: read address when mem_rd_en, else load pointer.
  - mem_rd_en and mem_wr_en are never both 1.

Decomposition:
- Shared package (ppu_common.vh): command nibble defines (PPU_MEMCMD_IDLE=0, PPU_MEMCMD_READ=1) and the FSM state encodings.
- The RAM itself lives outside this module.
- One natural sub-module: ppu_nibble_shifter, a 16-bit shift register with load and 4-bit shift. Instantiate it twice: address deserializer and data serializer.

Test Plan:
- Reset and idle:
  - rst_n low for 3 cycles with addr_pins=1 -> data_pins=0, busy=0, mem_rd_en=0, load_ready=1.
  - addr_pins held at 0 for 100 cycles -> no mem activity.
- Load then read:
  - load_start with load_addr=16'h1234, then words 16'hA5C3 and 16'h0F0F (2 handshakes) -> writes to addresses 1234 and 1235.
  - PPU stream 1,1,2,3,4 -> mem_rd_en at t5 with addr 1234.
  - data_pins = A,5,C,3 at t7..t10 (RESP_DELAY=2).
- Back-to-back and wrap-around:
  - Load at FFFF then 0000.
  - Read FFFF followed immediately by a read of 0000 (command nibble at the cycle after the last data nibble) -> both words returned correctly, no proto_err.
- Errors:
  - addr_pins=7 in IDLE -> proto_err pulses 1 cycle, state stays IDLE.
  - addr_pins=1 during DATA -> proto_err pulses and the current data nibbles are unchanged.
- Arbitration: load_valid held high across a read -> load_ready=0 only in the mem_rd_en cycle; no write lost or duplicated (check the pointer).
- Reset mid-transaction: rst_n low at a DATA nibble -> data_pins=0 next cycle; a fresh read afterwards succeeds.

Source files
------------

// File: rtl/ppu_ram_responder_pkg.sv
// Shared definitions for the PPU external-memory responder: command nibble
// codes, word width and the transaction FSM state encoding.
package ppu_ram_responder_pkg;

   localparam logic [3:0] PPU_MEMCMD_IDLE = 4'h0;
   localparam logic [3:0] PPU_MEMCMD_READ = 4'h1;
   localparam int         WORD_BITS       = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   // A command nibble seen in IDLE that is neither idle nor READ.
   function automatic logic is_illegal_cmd(input logic [3:0] nib);
      return (nib != PPU_MEMCMD_IDLE) && (nib != PPU_MEMCMD_READ);
   endfunction

endpackage

// File: rtl/ppu_nibble_shifter.sv
// W-bit shift register with parallel load and N-bit left shift (MSB first).
// Used both to assemble the serial address and to serialise read data.
module ppu_nibble_shifter #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic [N-1:0] shift_in,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   // Parallel load has priority over a shift; otherwise hold.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d = {q_q[W-N-1:0], shift_in};
      end else begin
         q_d = q_q;
      end
   end

   // Shift register storage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/ppu_ram_responder.sv
// PPU external-memory responder: decodes the serial READ/address stream,
// issues a single RAM read, returns the word as nibbles, and offers a host
// load port that writes RAM whenever the read path does not need the port.
module ppu_ram_responder
   import ppu_ram_responder_pkg::*;
#(
   parameter int RAM_PINS   = 4,
   parameter int ADDR_BITS  = 16,
   parameter int RESP_DELAY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [RAM_PINS-1:0]  addr_pins,
   output logic [RAM_PINS-1:0]  data_pins,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_rd_en,
   input  logic [WORD_BITS-1:0] mem_rdata,
   output logic                 mem_wr_en,
   output logic [WORD_BITS-1:0] mem_wdata,
   input  logic                 load_start,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic                 load_valid,
   input  logic [WORD_BITS-1:0] load_data,
   output logic                 load_ready,
   output logic                 busy,
   output logic                 proto_err
);

   localparam logic [2:0] ADDR_LAST = 3'(ADDR_BITS / RAM_PINS - 1);
   localparam logic [2:0] WAIT_LAST = 3'(RESP_DELAY - 1);
   localparam logic [2:0] DATA_LAST = 3'(WORD_BITS / RAM_PINS - 1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  rd_en_q, rd_en_d;
   logic                  cap_q, cap_d;
   logic                  err_q, err_d;
   logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
   logic [ADDR_BITS-1:0]  addr_word;
   logic [WORD_BITS-1:0]  data_word;
   logic                  accept;

   // A read strobe owns the RAM port, so the host is stalled in that cycle;
   // load_start takes precedence over a simultaneous handshake.
   assign load_ready = ~rd_en_q;
   assign accept     = load_valid & load_ready & ~load_start;

   // Next-state, counters and pulse outputs of the read transaction.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_en_d = 1'b0;
      cap_d   = rd_en_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 3'd0;
            if (addr_pins == PPU_MEMCMD_READ) begin
               state_d = ST_ADDR;
            end else if (is_illegal_cmd(addr_pins)) begin
               err_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (cnt_q == ADDR_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = 3'd0;
               rd_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_WAIT: begin
            err_d = (addr_pins != PPU_MEMCMD_IDLE);
            if (cnt_q == WAIT_LAST) begin
               state_d = ST_DATA;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_DATA: begin
            err_d = (addr_pins != PPU_MEMCMD_IDLE);
            if (cnt_q == DATA_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Load pointer: restart on load_start, advance (wrapping) per accepted word.
   always_comb begin
      if (load_start) begin
         ptr_d = load_addr;
      end else if (accept) begin
         ptr_d = ptr_q + PTR_ONE;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Single register stage for the FSM, its pulses and the load pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         rd_en_q <= 1'b0;
         cap_q   <= 1'b0;
         err_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_en_q <= rd_en_d;
         cap_q   <= cap_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
      end
   end

   ppu_nibble_shifter #(.W(ADDR_BITS), .N(RAM_PINS)) u_addr_deser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (1'b0),
      .load_val ('0),
      .shift    (state_q == ST_ADDR),
      .shift_in (addr_pins),
      .q        (addr_word)
   );

   // Read data arrives the cycle after the strobe and is held until DATA.
   ppu_nibble_shifter #(.W(WORD_BITS), .N(RAM_PINS)) u_data_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cap_q),
      .load_val (mem_rdata),
      .shift    (state_q == ST_DATA),
      .shift_in ('0),
      .q        (data_word)
   );

   assign data_pins = (state_q == ST_DATA) ? data_word[WORD_BITS-1:WORD_BITS-RAM_PINS] : '0;
   assign mem_rd_en = rd_en_q;
   assign mem_addr  = rd_en_q ? addr_word : ptr_q;
   assign mem_wr_en = accept;
   assign mem_wdata = accept ? load_data : '0;
   assign busy      = (state_q != ST_IDLE);
   assign proto_err = err_q;

endmodule

// File: tb/tb_ppu_ram_responder.sv
// Directed + randomized bench for ppu_ram_responder. The bench models the
// external RAM and keeps its own reference image of memory contents and of
// the expected load pointer; read timing is derived from the cycle offsets
// of the serial protocol (t0 = command nibble).
module tb_ppu_ram_responder;

   localparam int RD     = 2;
   localparam int DFIRST = RD + 5;   // first data nibble cycle, t4+RD+1
   localparam int LAST_K = RD + 8;   // last data nibble cycle

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  addr_pins;
   logic [3:0]  data_pins;
   logic [15:0] mem_addr;
   logic        mem_rd_en;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_wr_en;
   logic [15:0] mem_wdata;
   logic        load_start;
   logic [15:0] load_addr;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        busy;
   logic        proto_err;

   logic [15:0] ram     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] exp_ptr;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   ppu_ram_responder #(.RAM_PINS(4), .ADDR_BITS(16), .RESP_DELAY(RD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr_pins  (addr_pins),
      .data_pins  (data_pins),
      .mem_addr   (mem_addr),
      .mem_rd_en  (mem_rd_en),
      .mem_rdata  (mem_rdata),
      .mem_wr_en  (mem_wr_en),
      .mem_wdata  (mem_wdata),
      .load_start (load_start),
      .load_addr  (load_addr),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .busy       (busy),
      .proto_err  (proto_err)
   );

   // External synchronous single-port RAM.
   always @(posedge clk) begin
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic do_idle(input int n);
      for (int i = 0; i < n; i++) begin
         next();
         addr_pins = 4'h0; load_start = 1'b0; load_valid = 1'b0;
         #1;
         chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
         chk("idle_wr_en", 32'(mem_wr_en), 32'd0);
         chk("idle_data", 32'(data_pins), 32'd0);
         chk("idle_err", 32'(proto_err), 32'd0);
      end
   endtask

   // load_start with a simultaneous handshake: the handshake must be dropped.
   task automatic do_load_start(input logic [15:0] a);
      next();
      addr_pins = 4'h0; load_start = 1'b1; load_addr = a;
      load_valid = 1'b1; load_data = 16'(($urandom));
      #1;
      chk("start_no_write", 32'(mem_wr_en), 32'd0);
      exp_ptr = a;
   endtask

   task automatic do_word(input logic [15:0] d);
      next();
      addr_pins = 4'h0; load_start = 1'b0; load_valid = 1'b1; load_data = d;
      #1;
      chk("load_ready", 32'(load_ready), 32'd1);
      chk("wr_en", 32'(mem_wr_en), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'(exp_ptr));
      chk("wr_data", 32'(mem_wdata), 32'(d));
      ref_mem[exp_ptr] = d;
      exp_ptr = exp_ptr + 16'd1;
   endtask

   // One read transaction t0..t4+RD+4. err_k/rst_k < 0 disable injection.
   task automatic do_read(input logic [15:0] a, input bit hold_load,
                          input int err_k, input logic [3:0] err_nib, input int rst_k);
      logic [15:0] w;
      logic [3:0]  exp_nib;
      w = ref_mem[a];
      for (int k = 0; k <= LAST_K; k++) begin
         next();
         load_start = 1'b0;
         load_valid = hold_load;
         load_data  = 16'($urandom);
         if (rst_k >= 0 && k == rst_k + 1) begin
            rst_n = 1'b1; addr_pins = 4'h0; load_valid = 1'b0;
            #1;
            chk("rst_data", 32'(data_pins), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
            chk("rst_ready", 32'(load_ready), 32'd1);
            exp_ptr = 16'h0000;
            return;
         end
         rst_n = (rst_k >= 0 && k == rst_k) ? 1'b0 : 1'b1;
         if (k == 0)                   addr_pins = 4'h1;
         else if (k <= 4)              addr_pins = a[19-4*k -: 4];
         else if (k == err_k)          addr_pins = err_nib;
         else                          addr_pins = 4'h0;
         #1;
         exp_nib = (k >= DFIRST && k < DFIRST + 4) ? w[15-4*(k-DFIRST) -: 4] : 4'h0;
         chk("data_pins", 32'(data_pins), 32'(exp_nib));
         chk("rd_en", 32'(mem_rd_en), 32'(k == 5));
         if (k == 5) chk("rd_addr", 32'(mem_addr), 32'(a));
         chk("ready", 32'(load_ready), 32'(k != 5));
         chk("busy", 32'(busy), 32'(k >= 1));
         chk("proto_err", 32'(proto_err), 32'(err_k >= 0 && k == err_k + 1));
         chk("rd_wr_excl", 32'(mem_rd_en & mem_wr_en), 32'd0);
         if (hold_load) begin
            chk("arb_wr_en", 32'(mem_wr_en), 32'(k != 5));
            if (k != 5) begin
               chk("arb_wr_addr", 32'(mem_addr), 32'(exp_ptr));
               ref_mem[exp_ptr] = load_data;
               exp_ptr = exp_ptr + 16'd1;
            end
         end
      end
   endtask

   initial begin
      logic [15:0] base;
      int          n;
      rst_n = 1'b0; addr_pins = 4'h1; load_start = 1'b0; load_addr = 16'h0000;
      load_valid = 1'b0; load_data = 16'h0000; exp_ptr = 16'h0000;

      // Reset held for 3 cycles with a READ nibble present.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", 32'(data_pins), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
      chk("reset_wr_en", 32'(mem_wr_en), 32'd0);
      chk("reset_ready", 32'(load_ready), 32'd1);
      chk("reset_err", 32'(proto_err), 32'd0);
      chk("reset_ptr", 32'(mem_addr), 32'd0);
      next();
      rst_n = 1'b1; addr_pins = 4'h0;

      do_idle(100);

      // Load two words at 1234 and read them back.
      do_load_start(16'h1234);
      do_word(16'hA5C3);
      do_word(16'h0F0F);
      do_idle(1);
      do_read(16'h1234, 1'b0, -1, 4'h0, -1);
      do_read(16'h1235, 1'b0, -1, 4'h0, -1);
      do_idle(2);

      // Pointer wrap FFFF -> 0000, then back-to-back reads of both.
      do_load_start(16'hFFFF);
      do_word(16'($urandom));
      do_word(16'($urandom));
      chk("wrap_ptr", 32'(exp_ptr), 32'h1);
      do_idle(1);
      do_read(16'hFFFF, 1'b0, -1, 4'h0, -1);
      do_read(16'h0000, 1'b0, -1, 4'h0, -1);
      do_idle(1);

      // Illegal command in IDLE.
      next(); addr_pins = 4'h7; #1;
      chk("idle_err_pre", 32'(proto_err), 32'd0);
      next(); addr_pins = 4'h0; #1;
      chk("idle_err_pulse", 32'(proto_err), 32'd1);
      chk("idle_err_busy", 32'(busy), 32'd0);
      next(); #1;
      chk("idle_err_end", 32'(proto_err), 32'd0);
      chk("idle_err_busy2", 32'(busy), 32'd0);

      // READ nibble during DATA, and a stray nibble during WAIT.
      do_read(16'h1234, 1'b0, 8, 4'h1, -1);
      do_read(16'h1235, 1'b0, 5, 4'h9, -1);
      do_idle(1);

      // Arbitration: host streams words across a whole read.
      do_load_start(16'h8000);
      do_read(16'h1235, 1'b1, -1, 4'h0, -1);
      do_word(16'($urandom));
      chk("arb_ptr", 32'(exp_ptr), 32'h800B);
      do_idle(1);
      do_read(16'h8000, 1'b0, -1, 4'h0, -1);
      do_read(16'h8009, 1'b0, -1, 4'h0, -1);
      do_read(16'h800A, 1'b0, -1, 4'h0, -1);

      // Randomized loads and reads, some with stray nibbles.
      for (int i = 0; i < 16; i++) begin
         base = 16'($urandom);
         n = $urandom_range(3, 1);
         do_load_start(base);
         for (int j = 0; j < n; j++) do_word(16'($urandom));
         do_idle($urandom_range(2, 0));
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(1, 0) == 1)
               do_read(base + 16'(j), 1'b0, $urandom_range(9, 5), 4'($urandom_range(15, 1)), -1);
            else
               do_read(base + 16'(j), 1'b0, -1, 4'h0, -1);
         end
      end
      do_idle(1);

      // Reset in the middle of the data phase, then a fresh read.
      do_read(16'h1234, 1'b0, -1, 4'h0, 8);
      do_idle(1);
      do_read(16'h1234, 1'b0, -1, 4'h0, -1);
      do_word(16'h5A5A);
      do_idle(1);
      do_read(16'h0000, 1'b0, -1, 4'h0, -1);
      do_idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
